ltc2174_spi_master: RTL and testbench

- SPI initiator that configures the LTC2174 quad ADC from the FPGA side. It drives CS/SCK/SDI and samples SDO.
- Accepts one 16-bit register transaction per start request from a local control port (host register bank or init sequencer).
- Sits between the board-config logic and the ADC serial port. It also handles the ADC's active-low CS, which commits a write on the CS rising edge.

---
 rtl/ltc2174_spi_master.sv | 152 +++++++++++++++
 tb/tb_ltc2174_spi_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2174_spi_master.sv
// SPI initiator for the LTC2174 ADC serial port: one 16-bit CPOL0 frame per start request.
// Define LTC2174_SPI_READBACK_EN to follow every write with a verifying read of the same address.
module ltc2174_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rnw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       readback_err,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_sdi,
    input  logic       spi_sdo
);
    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                                   : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic [4:0]       bit_q, bit_d;
    logic             rnw_q, rnw_d, rb_q, rb_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d, rx_q, rx_d, rdata_q, rdata_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             cs_q, cs_d, sck_q, sck_d, sdi_q, sdi_d;
    logic             start_ok, rb_needed, rnw_eff_d;
    logic [15:0]      frame_d;

    assign start_ok = (state_q == IDLE) && start;

`ifdef LTC2174_SPI_READBACK_EN
    logic [7:0] rb_mask;
    assign rb_needed = !rnw_q && !rb_q;
    // Register 3 bit 6 always reads back as zero, so it is excluded from the compare.
    assign rb_mask   = (addr_q == 7'd3) ? 8'hBF : 8'hFF;
`else
    assign rb_needed = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;    cnt_q   <= '0;    div_q  <= '0;   phase_q <= 1'b0;
            bit_q   <= '0;      rnw_q   <= 1'b0;  rb_q   <= 1'b0; addr_q  <= '0;
            wdata_q <= '0;      rx_q    <= '0;    rdata_q <= '0;  busy_q  <= 1'b0;
            done_q  <= 1'b0;    err_q   <= 1'b0;  cs_q   <= 1'b1; sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q   <= cnt_d; div_q  <= div_d; phase_q <= phase_d;
            bit_q   <= bit_d;   rnw_q   <= rnw_d; rb_q   <= rb_d;  addr_q  <= addr_d;
            wdata_q <= wdata_d; rx_q    <= rx_d;  rdata_q <= rdata_d; busy_q <= busy_d;
            done_q  <= done_d;  err_q   <= err_d; cs_q   <= cs_d;  sck_q   <= sck_d;
            sdi_q   <= sdi_d;
        end
    end

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; div_d = div_q; phase_d = phase_q; bit_d = bit_q;
        rnw_d = rnw_q; rb_d = rb_q; addr_d = addr_q; wdata_d = wdata_q; rx_d = rx_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SETUP; cnt_d = '0; rb_d = 1'b0;
                rnw_d = rnw; addr_d = addr; wdata_d = wdata;
            end
            SETUP: if (cnt_q == SETUP_LAST) begin
                state_d = SHIFT; div_d = '0; phase_d = 1'b0; bit_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            SHIFT: if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    // SCK falls here; bits 7..14 carry the ADC's read byte MSB first.
                    phase_d = 1'b0;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q >= 5'd7 && bit_q <= 5'd14)
                        rx_d = {rx_q[6:0], spi_sdo};
                    if (bit_q == 5'd15) begin
                        state_d = HOLD; cnt_d = '0;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
            HOLD: if (cnt_q == HOLD_LAST) begin
                state_d = GAP; cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            GAP: if (cnt_q == IDLE_LAST) begin
                if (rb_needed) begin
                    state_d = SETUP; cnt_d = '0; rb_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values and registered so the pins never glitch.
    always_comb begin
        rnw_eff_d = rnw_d | rb_d;
        frame_d   = {rnw_eff_d, addr_d, rnw_eff_d ? 8'h00 : wdata_d};
        busy_d    = (state_d != IDLE);
        cs_d      = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        sck_d     = (state_d == SHIFT) && phase_d;
        sdi_d     = (state_d == SHIFT) ? frame_d[~bit_d[3:0]] : 1'b0;
        done_d    = (state_d == GAP) && (cnt_d == IDLE_LAST) && !rb_needed;
        rdata_d   = (done_d && rnw_eff_d) ? rx_d : rdata_q;
`ifdef LTC2174_SPI_READBACK_EN
        err_d = err_q;
        if (start_ok)
            err_d = 1'b0;
        else if (done_d && rb_d)
            err_d = |((rx_d ^ wdata_q) & rb_mask);
`else
        err_d = 1'b0;
`endif
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign readback_err = err_q;
    assign spi_cs       = cs_q;
    assign spi_sck      = sck_q;
    assign spi_sdi      = sdi_q;
endmodule

// File: tb/tb_ltc2174_spi_master.sv
// Bench for ltc2174_spi_master: ADC model on the serial pins, scoreboard of expected frames/results.
module tb_ltc2174_spi_master;
    logic       clk = 1'b0;
    logic       rst, start, start_f, rnw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done, err, spi_cs, spi_sck, spi_sdi, spi_sdo;
    logic [7:0] rdata;
    logic       busy_f, done_f, err_f, cs_f, sck_f, sdi_f, sdo_f;
    logic [7:0] rdata_f;

    always #5 clk = ~clk;

    ltc2174_spi_master dut (
        .clk(clk), .rst(rst), .start(start), .rnw(rnw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .readback_err(err),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo));

    ltc2174_spi_master #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .rnw(rnw), .addr(addr), .wdata(wdata),
        .busy(busy_f), .done(done_f), .rdata(rdata_f), .readback_err(err_f),
        .spi_cs(cs_f), .spi_sck(sck_f), .spi_sdi(sdi_f), .spi_sdo(sdo_f));

`ifdef LTC2174_SPI_READBACK_EN
    localparam int LAT_WR = 272;
`else
    localparam int LAT_WR = 136;
`endif
    localparam int LAT_RD = 136;

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model + pin monitor, one copy per instance
    logic [7:0]  adc_rd = 8'h00, adc_rd_f = 8'h00;
    int          rises = 0, cs_low = 0, done_cnt = 0, viol = 0;
    int          rises_f = 0, cs_low_f = 0;
    logic [15:0] sdi_cap = '0, sdi_cap_f = '0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_cs_f = 1'b1, prev_sck_f = 1'b0;
    logic [2:0]  sidx, sidx_f;

    assign sidx    = 3'(15 - rises);
    assign sidx_f  = 3'(15 - rises_f);
    assign spi_sdo = (rises >= 8 && rises <= 15) ? adc_rd[sidx] : 1'b0;
    assign sdo_f   = (rises_f >= 8 && rises_f <= 15) ? adc_rd_f[sidx_f] : 1'b0;

    always @(negedge clk) begin
        if (prev_cs && !spi_cs) begin
            rises <= 0; sdi_cap <= '0; cs_low <= 1;
        end else if (!spi_cs) begin
            cs_low <= cs_low + 1;
            if (spi_sck && !prev_sck) begin
                rises   <= rises + 1;
                sdi_cap <= {sdi_cap[14:0], spi_sdi};
            end
        end
        if (spi_cs && (spi_sdi || spi_sck)) viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
        prev_cs <= spi_cs; prev_sck <= spi_sck;

        if (prev_cs_f && !cs_f) begin
            rises_f <= 0; sdi_cap_f <= '0; cs_low_f <= 1;
        end else if (!cs_f) begin
            cs_low_f <= cs_low_f + 1;
            if (sck_f && !prev_sck_f) begin
                rises_f   <= rises_f + 1;
                sdi_cap_f <= {sdi_cap_f[14:0], sdi_f};
            end
        end
        if (cs_f && (sdi_f || sck_f)) viol <= viol + 1;
        prev_cs_f <= cs_f; prev_sck_f <= sck_f;
    end

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic       rnw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] adc;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[7];

    int last_t0 = 0, last_done_cyc = 0, txn = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] w,
                         input logic [7:0] adc, input logic [7:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (busy && n < 400) begin @(negedge clk); n++; end
        adc_rd = adc;
        rnw = r; addr = a; wdata = w; start = 1'b1;
        last_t0 = cyc;
        e.rdata = exp_rd; e.err = exp_err; e.t0 = cyc;
        if (r) begin
            e.frame = {1'b1, a, 8'h00}; e.lat = LAT_RD;
        end else begin
`ifdef LTC2174_SPI_READBACK_EN
            e.frame = {1'b1, a, 8'h00};
`else
            e.frame = {1'b0, a, w};
`endif
            e.lat = LAT_WR;
        end
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        logic got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        last_done_cyc = cyc;
        chk("sb_nonempty", sbq.size(), (sbq.size() == 0) ? 32'd1 : sbq.size());
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        txn++;
        $display("txn %0d: frame=%h rdata=%h err=%0d lat=%0d", txn, sdi_cap, rdata, err, cyc - e.t0);
        chk("frame", {16'd0, sdi_cap}, {16'd0, e.frame});
        chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
        chk("readback_err", {31'd0, err}, {31'd0, e.err});
        chk("latency", cyc - e.t0, e.lat);
        chk("cs_low_cycles", cs_low, 132);
    endtask

    initial begin
        automatic logic hit = 1'b0;
        automatic int d0;
        rst = 1'b1; start = 1'b0; start_f = 1'b0; rnw = 1'b0; addr = '0; wdata = '0;
        vecs[0] = '{1'b0, 7'h02, 8'h41, 8'h41, 8'h00};
        vecs[1] = '{1'b1, 7'h04, 8'h00, 8'h3E, 8'h3E};
        vecs[2] = '{1'b0, 7'h10, 8'hA5, 8'hA5, 8'h3E};
        vecs[3] = '{1'b1, 7'h7F, 8'h00, 8'hC3, 8'hC3};
        vecs[4] = '{1'b1, 7'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 7'h7F, 8'hFF, 8'hFF, 8'h00};
        vecs[6] = '{1'b1, 7'h55, 8'h00, 8'h81, 8'h81};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs",   {31'd0, spi_cs},  32'd1);
        chk("rst_sck",  {31'd0, spi_sck}, 32'd0);
        chk("rst_sdi",  {31'd0, spi_sdi}, 32'd0);
        chk("rst_busy", {31'd0, busy},    32'd0);
        chk("rst_done", {31'd0, done},    32'd0);
        chk("rst_rdata", {24'd0, rdata},  32'd0);
        chk("rst_err",  {31'd0, err},     32'd0);

        for (int i = 0; i < 7; i++) begin
`ifdef LTC2174_SPI_READBACK_EN
            issue(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].adc,
                  vecs[i].rnw ? vecs[i].exp_rd : vecs[i].adc, 1'b0);
`else
            issue(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].adc, vecs[i].exp_rd, 1'b0);
`endif
            wait_done();
            @(negedge clk);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end

        // Starts at cycles 10 and 70 of a transaction are dropped.
        d0 = done_cnt;
        issue(1'b1, 7'h21, 8'h00, 8'h6D, 8'h6D, 1'b0);
        while (cyc < last_t0 + 10) @(negedge clk);
        rnw = 1'b0; addr = 7'h33; wdata = 8'h99; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < last_t0 + 70) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();
        repeat (300) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after_ignored", {31'd0, busy}, 32'd0);

        // Back-to-back: start in the cycle busy falls.
        issue(1'b1, 7'h0A, 8'h00, 8'hB2, 8'hB2, 1'b0);
        wait_done();
        issue(1'b1, 7'h0B, 8'h00, 8'h4C, 8'h4C, 1'b0);
        chk("b2b_gap", last_t0 - last_done_cyc, 1);
        wait_done();

        // Async reset in the middle of a write frame.
        @(negedge clk);
        rnw = 1'b0; addr = 7'h05; wdata = 8'h77; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rises == 9) begin hit = 1'b1; break; end
        end
        chk("reached_rise9", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_cs",   {31'd0, spi_cs},  32'd1);
        chk("async_sck",  {31'd0, spi_sck}, 32'd0);
        chk("async_busy", {31'd0, busy},    32'd0);
        @(negedge clk); rst = 1'b0;
        issue(1'b1, 7'h01, 8'h00, 8'h5A, 8'h5A, 1'b0);
        wait_done();

`ifdef LTC2174_SPI_READBACK_EN
        issue(1'b0, 7'h03, 8'hC0, 8'h80, 8'h80, 1'b0);
        wait_done();
        issue(1'b0, 7'h04, 8'h55, 8'h54, 8'h54, 1'b1);
        wait_done();
`endif

        // Fast configuration: same frame format, shorter timing.
        @(negedge clk);
        adc_rd_f = 8'h3E; rnw = 1'b1; addr = 7'h04; wdata = 8'h00; start_f = 1'b1;
        d0 = cyc;
        @(negedge clk); start_f = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done_f) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        chk("fast_done_seen", {31'd0, hit}, 32'd1);
        txn++;
        $display("txn %0d: fast frame=%h rdata=%h lat=%0d", txn, sdi_cap_f, rdata_f, cyc - d0);
        chk("fast_latency", cyc - d0, 67);
        chk("fast_frame", {16'd0, sdi_cap_f}, 32'h8400);
        chk("fast_rdata", {24'd0, rdata_f}, 32'h3E);
        chk("fast_cs_low", cs_low_f, 66);
        @(negedge clk);
        chk("fast_busy_after", {31'd0, busy_f}, 32'd0);

        chk("sdi_sck_quiet_cs_high", viol, 0);
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
